// File: rtl/mcu_pkg.sv
// Shared opcodes, FSM states and control encodings
// for the multi-cycle RV32I control unit.
package mcu_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_MEM_ADDR = 4'd4,
    S_MEM_RD   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_WB_ALU   = 4'd7,
    S_WB_MEM   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_LUI      = 4'd12,
    S_AUIPC    = 4'd13,
    S_TRAP     = 4'd14
  } state_e;

  localparam logic [1:0] SRC_A_PC     = 2'b00;
  localparam logic [1:0] SRC_A_RS1    = 2'b01;
  localparam logic [1:0] SRC_A_ZERO   = 2'b10;
  localparam logic [1:0] SRC_A_OLD_PC = 2'b11;

  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_IMM  = 2'b01;
  localparam logic [1:0] SRC_B_FOUR = 2'b10;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JALR   = 2'b10;

  localparam logic [1:0] M2R_ALU  = 2'b00;
  localparam logic [1:0] M2R_MDR  = 2'b01;
  localparam logic [1:0] M2R_LINK = 2'b10;

  localparam logic [1:0] ALU_OP_R   = 2'b00;
  localparam logic [1:0] ALU_OP_I   = 2'b01;
  localparam logic [1:0] ALU_OP_BR  = 2'b10;
  localparam logic [1:0] ALU_OP_ADD = 2'b11;

  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       mem_req;
    logic       mem_we;
    logic       i_or_d;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       reg_write_en;
    logic [1:0] mem_to_reg;
    logic       instr_retired;
    logic       trap;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

  function automatic state_e decode_op(
    input logic [6:0] op,
    input logic       jalr_en,
    input logic       u_en
  );
    state_e s;
    s = S_TRAP;
    case (op)
      OP_R:      s = S_EXEC_R;
      OP_I:      s = S_EXEC_I;
      OP_LOAD:   s = S_MEM_ADDR;
      OP_STORE:  s = S_MEM_ADDR;
      OP_BRANCH: s = S_BRANCH;
      OP_JAL:    s = S_JAL;
      OP_JALR:   s = jalr_en ? S_JALR : S_TRAP;
      OP_LUI:    s = u_en ? S_LUI : S_TRAP;
      OP_AUIPC:  s = u_en ? S_AUIPC : S_TRAP;
      default:   s = S_TRAP;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mcu_out_decode.sv
// Per-state control decode; Mealy terms only on
// mem_ready (handshake) and branch_taken.
module mcu_out_decode
  import mcu_pkg::*;
(
  input  logic [3:0]        state,
  input  logic              mem_ready,
  input  logic              branch_taken,
  output logic [CTRL_W-1:0] ctrl
);

  ctrl_t c;

  always_comb begin
    c = '0;
    unique case (state_e'(state))
      S_FETCH: begin
        c.mem_req   = 1'b1;
        c.alu_src_a = SRC_A_PC;
        c.alu_src_b = SRC_B_FOUR;
        c.alu_op    = ALU_OP_ADD;
        c.pc_src    = PC_SRC_ALU;
        c.ir_write  = mem_ready;
        c.pc_write  = mem_ready;
      end
      S_DECODE: begin
        c.alu_src_a = SRC_A_OLD_PC;
        c.alu_src_b = SRC_B_IMM;
        c.alu_op    = ALU_OP_ADD;
      end
      S_EXEC_R: begin
        c.alu_src_a = SRC_A_RS1;
        c.alu_src_b = SRC_B_RS2;
        c.alu_op    = ALU_OP_R;
      end
      S_EXEC_I: begin
        c.alu_src_a = SRC_A_RS1;
        c.alu_src_b = SRC_B_IMM;
        c.alu_op    = ALU_OP_I;
      end
      S_MEM_ADDR: begin
        c.alu_src_a = SRC_A_RS1;
        c.alu_src_b = SRC_B_IMM;
        c.alu_op    = ALU_OP_ADD;
      end
      S_MEM_RD: begin
        c.mem_req = 1'b1;
        c.i_or_d  = 1'b1;
      end
      S_MEM_WR: begin
        c.mem_req       = 1'b1;
        c.mem_we        = 1'b1;
        c.i_or_d        = 1'b1;
        c.instr_retired = mem_ready;
      end
      S_WB_ALU: begin
        c.reg_write_en  = 1'b1;
        c.mem_to_reg    = M2R_ALU;
        c.instr_retired = 1'b1;
      end
      S_WB_MEM: begin
        c.reg_write_en  = 1'b1;
        c.mem_to_reg    = M2R_MDR;
        c.instr_retired = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a     = SRC_A_RS1;
        c.alu_src_b     = SRC_B_RS2;
        c.alu_op        = ALU_OP_BR;
        c.pc_src        = PC_SRC_ALUOUT;
        c.pc_write      = branch_taken;
        c.instr_retired = 1'b1;
      end
      S_JAL: begin
        c.pc_src        = PC_SRC_ALUOUT;
        c.pc_write      = 1'b1;
        c.reg_write_en  = 1'b1;
        c.mem_to_reg    = M2R_LINK;
        c.instr_retired = 1'b1;
      end
      S_JALR: begin
        c.alu_src_a     = SRC_A_RS1;
        c.alu_src_b     = SRC_B_IMM;
        c.alu_op        = ALU_OP_ADD;
        c.pc_src        = PC_SRC_JALR;
        c.pc_write      = 1'b1;
        c.reg_write_en  = 1'b1;
        c.mem_to_reg    = M2R_LINK;
        c.instr_retired = 1'b1;
      end
      S_LUI: begin
        c.alu_src_a     = SRC_A_ZERO;
        c.alu_src_b     = SRC_B_IMM;
        c.alu_op        = ALU_OP_ADD;
        c.reg_write_en  = 1'b1;
        c.mem_to_reg    = M2R_ALU;
        c.instr_retired = 1'b1;
      end
      // AUIPC target was already latched in ALUOut during DECODE
      S_AUIPC: begin
        c.reg_write_en  = 1'b1;
        c.mem_to_reg    = M2R_ALU;
        c.instr_retired = 1'b1;
      end
      S_TRAP: c.trap = 1'b1;
      default: c.trap = 1'b1;
    endcase
  end

  assign ctrl = c;

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM with memory handshake.
// Optional wait timeout: define MCU_MEM_TIMEOUT_EN.
module multicycle_control_unit
  import mcu_pkg::*;
#(
  parameter int ALU_OP_W       = 2,
  parameter int SUPPORT_JALR   = 1,
  parameter int SUPPORT_U_TYPE = 1,
  parameter int MEM_TIMEOUT    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [6:0]          opcode,
  input  logic                mem_ready,
  input  logic                branch_taken,
  output logic                pc_write,
  output logic                ir_write,
  output logic                mem_req,
  output logic                mem_we,
  output logic                i_or_d,
  output logic [1:0]          alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic [1:0]          pc_src,
  output logic                reg_write_en,
  output logic [1:0]          mem_to_reg,
  output logic                illegal_instr,
  output logic                bus_err,
  output logic                instr_retired,
  output logic [3:0]          state_o
);

  state_e            state_q, state_d;
  logic [CTRL_W-1:0] ctrl_raw;
  ctrl_t             raw;
  ctrl_t             ctrl;
  logic              to_hit;
  logic              bus_flag;

  mcu_out_decode u_dec (
    .state        (state_q),
    .mem_ready    (mem_ready),
    .branch_taken (branch_taken),
    .ctrl         (ctrl_raw)
  );

  assign raw = ctrl_raw;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE:   state_d = decode_op(opcode,
                    SUPPORT_JALR != 0, SUPPORT_U_TYPE != 0);
      S_EXEC_R:   state_d = S_WB_ALU;
      S_EXEC_I:   state_d = S_WB_ALU;
      S_MEM_ADDR: state_d = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   if (mem_ready) state_d = S_WB_MEM;
      S_MEM_WR:   if (mem_ready) state_d = S_FETCH;
      S_WB_ALU:   state_d = S_FETCH;
      S_WB_MEM:   state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JAL:      state_d = S_FETCH;
      S_JALR:     state_d = S_FETCH;
      S_LUI:      state_d = S_FETCH;
      S_AUIPC:    state_d = S_FETCH;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_TRAP;
    endcase
    if (to_hit) state_d = S_TRAP;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

`ifdef MCU_MEM_TIMEOUT_EN
  logic [7:0] wcnt_q, wcnt_d;
  logic       bus_q, bus_d;
  logic       wait_c;

  assign wait_c = raw.mem_req & ~mem_ready;
  assign to_hit = wait_c &&
    (({1'b0, wcnt_q} + 9'd1) == 9'(MEM_TIMEOUT));

  // counter restarts on every state entry
  always_comb begin
    wcnt_d = wcnt_q;
    if (state_d != state_q) wcnt_d = '0;
    else if (wait_c)        wcnt_d = wcnt_q + 8'd1;
    bus_d = bus_q | to_hit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt_q <= '0;
      bus_q  <= 1'b0;
    end else begin
      wcnt_q <= wcnt_d;
      bus_q  <= bus_d;
    end
  end

  assign bus_flag = bus_q;
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = MEM_TIMEOUT;
  assign to_hit   = 1'b0;
  assign bus_flag = 1'b0;
`endif

  always_comb begin
    ctrl = raw;
    if (rst) ctrl = '0;
  end

  assign pc_write      = ctrl.pc_write;
  assign ir_write      = ctrl.ir_write;
  assign mem_req       = ctrl.mem_req;
  assign mem_we        = ctrl.mem_we;
  assign i_or_d        = ctrl.i_or_d;
  assign alu_src_a     = ctrl.alu_src_a;
  assign alu_src_b     = ctrl.alu_src_b;
  assign alu_op        = ALU_OP_W'(ctrl.alu_op);
  assign pc_src        = ctrl.pc_src;
  assign reg_write_en  = ctrl.reg_write_en;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign instr_retired = ctrl.instr_retired;
  assign illegal_instr = ctrl.trap & ~bus_flag;
  assign bus_err       = ctrl.trap & bus_flag;
  assign state_o       = rst ? 4'd0 : state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed scoreboard bench for multicycle_control_unit;
// a second instance runs with JALR and U-type disabled.
module tb_multicycle_control_unit;
  import mcu_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opcode;
  logic       mem_ready;
  logic       branch_taken;

  always #5 clk = ~clk;

  logic       pcw, irw, req, we, iod, rwe, ill, be, ret;
  logic [1:0] sa, sb, op, pcs, m2r;
  logic [3:0] st;

  logic       pcw2, irw2, req2, we2, iod2, rwe2, ill2, be2, ret2;
  logic [1:0] sa2, sb2, op2, pcs2, m2r2;
  logic [3:0] st2;

  multicycle_control_unit #(
    .ALU_OP_W(2), .SUPPORT_JALR(1),
    .SUPPORT_U_TYPE(1), .MEM_TIMEOUT(4)
  ) dut (
    .clk(clk), .rst(rst), .opcode(opcode),
    .mem_ready(mem_ready), .branch_taken(branch_taken),
    .pc_write(pcw), .ir_write(irw), .mem_req(req),
    .mem_we(we), .i_or_d(iod), .alu_src_a(sa),
    .alu_src_b(sb), .alu_op(op), .pc_src(pcs),
    .reg_write_en(rwe), .mem_to_reg(m2r),
    .illegal_instr(ill), .bus_err(be),
    .instr_retired(ret), .state_o(st)
  );

  multicycle_control_unit #(
    .ALU_OP_W(2), .SUPPORT_JALR(0),
    .SUPPORT_U_TYPE(0), .MEM_TIMEOUT(16)
  ) dut2 (
    .clk(clk), .rst(rst), .opcode(opcode),
    .mem_ready(mem_ready), .branch_taken(branch_taken),
    .pc_write(pcw2), .ir_write(irw2), .mem_req(req2),
    .mem_we(we2), .i_or_d(iod2), .alu_src_a(sa2),
    .alu_src_b(sb2), .alu_op(op2), .pc_src(pcs2),
    .reg_write_en(rwe2), .mem_to_reg(m2r2),
    .illegal_instr(ill2), .bus_err(be2),
    .instr_retired(ret2), .state_o(st2)
  );

  typedef struct {
    string       tag;
    logic        rdy;
    logic        tkn;
    logic        rs;
    logic [27:0] e;
    logic [27:0] m;
  } step_t;

  step_t q[$];
  int    total = 0;
  int    bad   = 0;
  int    tr    = 14;

  // '0'/'1' are required bits, 'x' is a don't-care
  task automatic bits(input string s,
                      output logic [15:0] v,
                      output logic [15:0] m);
    v = '0;
    m = '0;
    for (int i = 0; i < s.len(); i++) begin
      int b;
      b = s.len() - 1 - i;
      v[b[3:0]] = (s[i] == "1");
      m[b[3:0]] = (s[i] != "x");
    end
  endtask

  // en: {pcw,irw,req,we,iod,rwe,ret}
  // mx: {m2r,pcs,sa,sb,op}  fl: {ill,bus_err}
  task automatic push(input string tag,
                      input logic rdy, input logic tkn,
                      input logic rs, input state_e s,
                      input string en, input string mx,
                      input string fl,
                      input int d2st = -1,
                      input int d2ill = -1);
    logic [27:0] e, m;
    logic [15:0] v1, m1;
    e = '0;
    m = '0;
    e[27:24] = s;
    m[27:24] = 4'hf;
    bits(en, v1, m1);
    e[23:17] = v1[6:0];
    m[23:17] = m1[6:0];
    bits(mx, v1, m1);
    e[16:7] = v1[9:0];
    m[16:7] = m1[9:0];
    bits(fl, v1, m1);
    e[6:5] = v1[1:0];
    m[6:5] = m1[1:0];
    if (d2st >= 0) begin
      e[4:1] = d2st[3:0];
      m[4:1] = 4'hf;
      e[0]   = d2ill[0];
      m[0]   = 1'b1;
    end
    q.push_back('{tag, rdy, tkn, rs, e, m});
  endtask

  task automatic rst_step(input logic rdy);
    push("rst", rdy, 1'b1, 1'b1, S_FETCH, "0000000",
         "0000000000", "00", 0, 0);
  endtask

  task automatic fetch(input int nw,
                       input int d2st = -1,
                       input int d2ill = -1);
    for (int i = 0; i < nw; i++)
      push("fetch_wait", 1'b0, 1'b0, 1'b0, S_FETCH, "0010000",
           "xxxx001011", "00", d2st, d2ill);
    push("fetch", 1'b1, 1'b0, 1'b0, S_FETCH, "1110000",
         "xx00001011", "00", d2st, d2ill);
  endtask

  task automatic dec(input int d2st = -1,
                     input int d2ill = -1);
    push("decode", 1'b1, 1'b0, 1'b0, S_DECODE, "0000x00",
         "xxxx110111", "00", d2st, d2ill);
  endtask

  task automatic drain();
    step_t       s;
    logic [27:0] obs;
    while (q.size() > 0) begin
      s = q.pop_front();
      mem_ready    = s.rdy;
      branch_taken = s.tkn;
      rst          = s.rs;
      @(negedge clk);
      obs = {st, pcw, irw, req, we, iod, rwe, ret,
             m2r, pcs, sa, sb, op, ill, be, st2, ill2};
      total++;
      assert ((obs & s.m) === (s.e & s.m)) else begin
        bad++;
        $error("FAIL %s: got %h want %h mask %h",
               s.tag, obs & s.m, s.e & s.m, s.m);
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst          = 1'b1;
    opcode       = OP_R;
    mem_ready    = 1'b0;
    branch_taken = 1'b0;

    rst_step(1'b1);
    rst_step(1'b1);
    drain();

    opcode = OP_R;
    fetch(0, 0, 0);
    dec(1, 0);
    push("exec_r", 1'b1, 1'b0, 1'b0, S_EXEC_R, "0000x00",
         "xxxx010000", "00", 2, 0);
    push("wb_alu", 1'b1, 1'b0, 1'b0, S_WB_ALU, "0000x11",
         "00xxxxxxxx", "00", 7, 0);
    drain();

    opcode = OP_LOAD;
    fetch(0);
    dec();
    push("mem_addr", 1'b1, 1'b0, 1'b0, S_MEM_ADDR, "0000x00",
         "xxxx010111", "00");
    for (int i = 0; i < 3; i++)
      push("rd_wait", 1'b0, 1'b0, 1'b0, S_MEM_RD, "0010100",
           "xxxxxxxxxx", "00");
    push("rd", 1'b1, 1'b0, 1'b0, S_MEM_RD, "0010100",
         "xxxxxxxxxx", "00");
    push("wb_mem", 1'b0, 1'b0, 1'b0, S_WB_MEM, "0000x11",
         "01xxxxxxxx", "00");
    drain();

    opcode = OP_STORE;
    fetch(0);
    dec();
    push("mem_addr", 1'b0, 1'b0, 1'b0, S_MEM_ADDR, "0000x00",
         "xxxx010111", "00");
    push("wr_wait", 1'b0, 1'b0, 1'b0, S_MEM_WR, "0011100",
         "xxxxxxxxxx", "00");
    push("wr", 1'b1, 1'b0, 1'b0, S_MEM_WR, "0011101",
         "xxxxxxxxxx", "00");
    drain();

    opcode = OP_I;
    fetch(2);
    dec();
    push("exec_i", 1'b1, 1'b0, 1'b0, S_EXEC_I, "0000x00",
         "xxxx010101", "00");
    push("wb_alu", 1'b1, 1'b0, 1'b0, S_WB_ALU, "0000x11",
         "00xxxxxxxx", "00");
    drain();

    opcode = OP_BRANCH;
    fetch(0);
    dec();
    push("br_nt", 1'b1, 1'b0, 1'b0, S_BRANCH, "0000x01",
         "xxxx010010", "00");
    fetch(0);
    dec();
    push("br_t", 1'b1, 1'b1, 1'b0, S_BRANCH, "1000x01",
         "xx01010010", "00");
    drain();

    opcode = OP_JAL;
    fetch(0);
    dec();
    push("jal", 1'b1, 1'b0, 1'b0, S_JAL, "1000x11",
         "1001xxxxxx", "00", 10, 0);
    drain();

    opcode = OP_LUI;
    fetch(0);
    dec();
    push("lui", 1'b1, 1'b0, 1'b0, S_LUI, "0000x11",
         "00xx100111", "00", tr, 1);
    rst_step(1'b1);
    drain();

    opcode = OP_AUIPC;
    fetch(0);
    dec();
    push("auipc", 1'b1, 1'b0, 1'b0, S_AUIPC, "0000x11",
         "00xxxxxxxx", "00", tr, 1);
    rst_step(1'b1);
    drain();

    opcode = OP_JALR;
    fetch(0, 0, 0);
    dec(1, 0);
    push("jalr", 1'b1, 1'b0, 1'b0, S_JALR, "1000x11",
         "1010010111", "00", tr, 1);
    drain();
    opcode = OP_R;
    fetch(0, tr, 1);
    dec(tr, 1);
    push("exec_r", 1'b1, 1'b0, 1'b0, S_EXEC_R, "0000x00",
         "xxxx010000", "00", tr, 1);
    push("wb_alu", 1'b1, 1'b0, 1'b0, S_WB_ALU, "0000x11",
         "00xxxxxxxx", "00", tr, 1);
    rst_step(1'b0);
    drain();

    opcode = 7'h7f;
    fetch(0);
    dec();
    for (int i = 0; i < 20; i++)
      push("trap", i[0], i[1], 1'b0, S_TRAP, "0000x00",
           "xxxxxxxxxx", "10", tr, 1);
    rst_step(1'b1);
    drain();
    opcode = OP_R;
    fetch(0, 0, 0);
    dec(1, 0);
    drain();
    push("exec_r", 1'b1, 1'b0, 1'b0, S_EXEC_R, "0000x00",
         "xxxx010000", "00");
    push("wb_alu", 1'b1, 1'b0, 1'b0, S_WB_ALU, "0000x11",
         "00xxxxxxxx", "00");
    drain();

    push("fetch_wait", 1'b0, 1'b0, 1'b0, S_FETCH, "0010000",
         "xxxx001011", "00");
    push("fetch_wait", 1'b0, 1'b0, 1'b0, S_FETCH, "0010000",
         "xxxx001011", "00");
    push("rst_mid", 1'b0, 1'b0, 1'b1, S_FETCH, "0000000",
         "0000000000", "00", 0, 0);
    fetch(1);
    dec();
    push("exec_r", 1'b1, 1'b0, 1'b0, S_EXEC_R, "0000x00",
         "xxxx010000", "00");
    drain();

`ifdef MCU_MEM_TIMEOUT_EN
    rst_step(1'b0);
    for (int i = 0; i < 4; i++)
      push("to_wait", 1'b0, 1'b0, 1'b0, S_FETCH, "0010000",
           "xxxx001011", "00");
    for (int i = 0; i < 3; i++)
      push("to_trap", 1'b0, 1'b0, 1'b0, S_TRAP, "0000x00",
           "xxxxxxxxxx", "01");
    rst_step(1'b0);
    drain();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
